dmem_multiport: RTL and testbench

//   Parametrised N-port data memory for the superscalar MEM stage; successor of the fixed dual-port data memory.

---
 rtl/dmem_multiport.sv | 107 ++++++++++
 tb/tb_dmem_multiport.sv | 137 +++++++++++++
 2 files changed

// File: rtl/dmem_multiport.sv
// N-port word-addressed data memory with byte-masked stores, registered loads,
// optional same-cycle store-to-load forwarding and a post-reset clear sweep.
module dmem_multiport #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 8,
    parameter int NPORTS = 2,
    parameter int BYPASS = 1
) (
    input  logic                       m_clk,
    input  logic                       m_rst,
    input  logic                       m_i_ce,
    input  logic [NPORTS-1:0]          m_i_wr_en,
    input  logic [NPORTS*DWIDTH/8-1:0] m_i_mask,
    input  logic [NPORTS*AWIDTH-1:0]   m_i_alu_value,
    input  logic [NPORTS*DWIDTH-1:0]   m_i_data_rs,
    output logic [NPORTS*DWIDTH-1:0]   m_o_load_data,
    output logic [NPORTS-1:0]          m_o_load_valid,
    output logic                       m_o_ready
);
    localparam int NLANES = DWIDTH / 8;
    localparam int DEPTH  = 2 ** AWIDTH;

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t                     r_state;
    logic [AWIDTH-1:0]          r_ptr;
    logic                       r_ready;
    logic [DWIDTH-1:0]          r_mem [DEPTH];
    logic [NPORTS*DWIDTH-1:0]   r_load_data;
    logic [NPORTS-1:0]          r_load_valid;

    logic                       w_accept;
    logic [DWIDTH-1:0]          w_rd_word [NPORTS];

    assign w_accept       = m_i_ce & r_ready;
    assign m_o_load_data  = r_load_data;
    assign m_o_load_valid = r_load_valid;
    assign m_o_ready      = r_ready;

    // Load word per port; with forwarding, same-address store lanes overlay the
    // array bytes in ascending port order so the highest store port wins.
    always_comb begin
        for (int p = 0; p < NPORTS; p++) begin
            w_rd_word[p] = r_mem[m_i_alu_value[p*AWIDTH +: AWIDTH]];
            if (BYPASS != 0) begin
                for (int q = 0; q < NPORTS; q++) begin
                    if (q != p && m_i_wr_en[q] &&
                        m_i_alu_value[q*AWIDTH +: AWIDTH] == m_i_alu_value[p*AWIDTH +: AWIDTH]) begin
                        for (int k = 0; k < NLANES; k++) begin
                            if (m_i_mask[q*NLANES + k])
                                w_rd_word[p][8*k +: 8] = m_i_data_rs[q*DWIDTH + 8*k +: 8];
                        end
                    end
                end
            end
        end
    end

    // Control: clear-sweep FSM, ready flag and registered load outputs.
    always_ff @(posedge m_clk) begin
        if (m_rst) begin
            r_state      <= S_INIT;
            r_ptr        <= '0;
            r_ready      <= 1'b0;
            r_load_data  <= '0;
            r_load_valid <= '0;
        end else begin
            case (r_state)
                S_INIT: begin
                    r_ptr <= r_ptr + 1'b1;
                    if (r_ptr == '1) begin
                        r_state <= S_RUN;
                        r_ready <= 1'b1;
                    end
                end
                S_RUN:   r_state <= S_RUN;
                default: r_state <= S_INIT;
            endcase
            for (int p = 0; p < NPORTS; p++) begin
                if (w_accept && !m_i_wr_en[p]) begin
                    r_load_data[p*DWIDTH +: DWIDTH] <= w_rd_word[p];
                    r_load_valid[p]                 <= 1'b1;
                end else begin
                    r_load_valid[p] <= 1'b0;
                end
            end
        end
    end

    // Array: later ports' byte writes override earlier ones on the same lane.
    always_ff @(posedge m_clk) begin
        if (!m_rst) begin
            if (r_state == S_INIT) begin
                r_mem[r_ptr] <= '0;
            end else if (w_accept) begin
                for (int q = 0; q < NPORTS; q++) begin
                    for (int k = 0; k < NLANES; k++) begin
                        if (m_i_wr_en[q] && m_i_mask[q*NLANES + k])
                            r_mem[m_i_alu_value[q*AWIDTH +: AWIDTH]][8*k +: 8]
                                <= m_i_data_rs[q*DWIDTH + 8*k +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_multiport.sv
// Directed bench for dmem_multiport: one instance with forwarding, one without,
// driven by identical stimulus.
module tb_dmem_multiport;
    logic        m_clk = 1'b0;
    logic        m_rst;
    logic        m_i_ce;
    logic [1:0]  m_i_wr_en;
    logic [7:0]  m_i_mask;
    logic [15:0] m_i_alu_value;
    logic [63:0] m_i_data_rs;
    logic [63:0] w_ld_byp, w_ld_nob;
    logic [1:0]  w_vld_byp, w_vld_nob;
    logic        w_rdy_byp, w_rdy_nob;

    int checks = 0;
    int errors = 0;

    always #5 m_clk = ~m_clk;

    dmem_multiport #(.DWIDTH(32), .AWIDTH(8), .NPORTS(2), .BYPASS(1)) u_dut_byp (
        .m_clk(m_clk), .m_rst(m_rst), .m_i_ce(m_i_ce), .m_i_wr_en(m_i_wr_en),
        .m_i_mask(m_i_mask), .m_i_alu_value(m_i_alu_value), .m_i_data_rs(m_i_data_rs),
        .m_o_load_data(w_ld_byp), .m_o_load_valid(w_vld_byp), .m_o_ready(w_rdy_byp));

    dmem_multiport #(.DWIDTH(32), .AWIDTH(8), .NPORTS(2), .BYPASS(0)) u_dut_nob (
        .m_clk(m_clk), .m_rst(m_rst), .m_i_ce(m_i_ce), .m_i_wr_en(m_i_wr_en),
        .m_i_mask(m_i_mask), .m_i_alu_value(m_i_alu_value), .m_i_data_rs(m_i_data_rs),
        .m_o_load_data(w_ld_nob), .m_o_load_valid(w_vld_nob), .m_o_ready(w_rdy_nob));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Drive one cycle of port requests, then sample 1 time unit after the edge.
    task automatic cyc(input logic ce,
                       input logic wr1, input logic [3:0] m1, input logic [7:0] a1, input logic [31:0] d1,
                       input logic wr0, input logic [3:0] m0, input logic [7:0] a0, input logic [31:0] d0);
        m_i_ce        = ce;
        m_i_wr_en     = {wr1, wr0};
        m_i_mask      = {m1, m0};
        m_i_alu_value = {a1, a0};
        m_i_data_rs   = {d1, d0};
        @(posedge m_clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b1, 4'h0, 8'h00, 32'h0, 1'b1, 4'h0, 8'h00, 32'h0);
    endtask

    // Counts edges after reset release until ready rises; bounded.
    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!w_rdy_byp && n < 400) begin
            idle();
            n++;
        end
        chk({tag, "_sweep_cycles"}, n, 256);
        chk({tag, "_ready_nob"}, {31'b0, w_rdy_nob}, 1);
    endtask

    initial begin
        m_rst = 1'b1;
        m_i_ce = 1'b0;
        m_i_wr_en = '0;
        m_i_mask = '0;
        m_i_alu_value = '0;
        m_i_data_rs = '0;
        @(posedge m_clk); @(posedge m_clk); #1;

        // T1: reset state, sweep length, cleared contents
        chk("rst_ready",  {31'b0, w_rdy_byp}, 0);
        chk("rst_valid",  {30'b0, w_vld_byp}, 0);
        chk("rst_data0",  w_ld_byp[31:0], 32'h0);
        m_rst = 1'b0;
        wait_ready("t1");
        cyc(1'b1, 1'b0, 4'h0, 8'd200, 32'h0, 1'b0, 4'h0, 8'd0, 32'h0);
        chk("t1_valid", {30'b0, w_vld_byp}, 32'h3);
        chk("t1_ld0",   w_ld_byp[31:0],  32'h0);
        chk("t1_ld1",   w_ld_byp[63:32], 32'h0);

        // T2: full store then load on the other port
        cyc(1'b1, 1'b1, 4'h0, 8'd0, 32'h0, 1'b1, 4'hF, 8'd3, 32'hAABBCCDD);
        chk("t2_store_novalid", {30'b0, w_vld_byp}, 0);
        cyc(1'b1, 1'b0, 4'h0, 8'd3, 32'h0, 1'b1, 4'h0, 8'd0, 32'h0);
        chk("t2_ld1",    w_ld_byp[63:32], 32'hAABBCCDD);
        chk("t2_valid",  {30'b0, w_vld_byp}, 32'h2);

        // T3: partial store, then empty-mask store
        cyc(1'b1, 1'b1, 4'h0, 8'd0, 32'h0, 1'b1, 4'h3, 8'd3, 32'h0000EEFF);
        cyc(1'b1, 1'b0, 4'h0, 8'd3, 32'h0, 1'b1, 4'h0, 8'd0, 32'h0);
        chk("t3_partial", w_ld_byp[63:32], 32'hAABBEEFF);
        cyc(1'b1, 1'b1, 4'h0, 8'd0, 32'h0, 1'b1, 4'h0, 8'd3, 32'hFFFFFFFF);
        cyc(1'b1, 1'b0, 4'h0, 8'd3, 32'h0, 1'b1, 4'h0, 8'd0, 32'h0);
        chk("t3_nomask", w_ld_byp[63:32], 32'hAABBEEFF);

        // T4: store-store conflict on addr 5
        cyc(1'b1, 1'b1, 4'h5, 8'd5, 32'h22222222, 1'b1, 4'hF, 8'd5, 32'h11111111);
        cyc(1'b1, 1'b0, 4'h0, 8'd5, 32'h0, 1'b1, 4'h0, 8'd0, 32'h0);
        chk("t4_conflict", w_ld_byp[63:32], 32'h11221122);
        chk("t4_conflict_nob", w_ld_nob[63:32], 32'h11221122);

        // T5: same-cycle load/store on addr 7
        cyc(1'b1, 1'b0, 4'h0, 8'd7, 32'h0, 1'b1, 4'hC, 8'd7, 32'h12345678);
        chk("t5_bypass",   w_ld_byp[63:32], 32'h12340000);
        chk("t5_nobypass", w_ld_nob[63:32], 32'h00000000);
        cyc(1'b1, 1'b0, 4'h0, 8'd7, 32'h0, 1'b0, 4'h0, 8'd7, 32'h0);
        chk("t5_after_p0", w_ld_nob[31:0],  32'h12340000);
        chk("t5_after_p1", w_ld_nob[63:32], 32'h12340000);
        chk("t5_both_vld", {30'b0, w_vld_nob}, 32'h3);

        // T6: disabled stores, then reset during run
        cyc(1'b0, 1'b1, 4'hF, 8'd7, 32'hFFFFFFFF, 1'b1, 4'hF, 8'd7, 32'hFFFFFFFF);
        chk("t6_ce0_novalid", {30'b0, w_vld_byp}, 0);
        chk("t6_ce0_hold",    w_ld_byp[63:32], 32'h12340000);
        cyc(1'b1, 1'b0, 4'h0, 8'd7, 32'h0, 1'b1, 4'h0, 8'd0, 32'h0);
        chk("t6_ce0_unchanged", w_ld_byp[63:32], 32'h12340000);
        m_rst = 1'b1;
        cyc(1'b1, 1'b0, 4'h0, 8'd7, 32'h0, 1'b0, 4'h0, 8'd3, 32'h0);
        chk("t6_rst_ready", {31'b0, w_rdy_byp}, 0);
        chk("t6_rst_valid", {30'b0, w_vld_byp}, 0);
        chk("t6_rst_data1", w_ld_byp[63:32], 32'h0);
        m_rst = 1'b0;
        wait_ready("t6");
        cyc(1'b1, 1'b0, 4'h0, 8'd7, 32'h0, 1'b0, 4'h0, 8'd3, 32'h0);
        chk("t6_cleared3", w_ld_byp[31:0],  32'h0);
        chk("t6_cleared7", w_ld_byp[63:32], 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
